// File: rtl/dcm_lock_ctrl_if.sv
// DCM lock sequencer signal bundle.
// Optional LOCK_LOSS_CNT_EN adds the lost_count lock-loss counter.
interface dcm_lock_ctrl_if;
  logic       dcm_locked;
  logic       relock;
  logic       dcm_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retries;
`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] lost_count;

  // Controller side
  modport master (
    input  dcm_locked, relock,
    output dcm_rst, sys_rst, ready, fail, retries, lost_count
  );

  // DCM / system side
  modport slave (
    output dcm_locked, relock,
    input  dcm_rst, sys_rst, ready, fail, retries, lost_count
  );
`else
  // Controller side
  modport master (
    input  dcm_locked, relock,
    output dcm_rst, sys_rst, ready, fail, retries
  );

  // DCM / system side
  modport slave (
    output dcm_locked, relock,
    input  dcm_rst, sys_rst, ready, fail, retries
  );
`endif
endinterface

// File: rtl/dcm_lock_ctrl.sv
// DCM reset/lock sequencer: pulses DCM RST, waits for LOCKED with timeout and
// retry, requires a stable lock before releasing sys_rst, restarts on lock loss.
// Optional LOCK_LOSS_CNT_EN: adds lost_count, a saturating count of RUN lock losses.
module dcm_lock_ctrl #(
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  dcm_lock_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_DCM,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       retries_q, retries_nxt;
  logic             sync_q, lk;
  logic             dcm_rst_q, sys_rst_q, ready_q, fail_q;
  logic             dcm_rst_nxt, sys_rst_nxt, ready_nxt, fail_nxt;
`ifdef LOCK_LOSS_CNT_EN
  logic             loss_c;
  logic [7:0]       lost_q;
`endif

  // Two-flop synchroniser for the asynchronous LOCKED pin
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b0;
      lk     <= 1'b0;
    end else begin
      sync_q <= bus.dcm_locked;
      lk     <= sync_q;
    end
  end

  // State, counter, retry count and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_RESET_DCM;
      cnt       <= '0;
      retries_q <= '0;
      dcm_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retries_q <= retries_nxt;
      dcm_rst_q <= dcm_rst_nxt;
      sys_rst_q <= sys_rst_nxt;
      ready_q   <= ready_nxt;
      fail_q    <= fail_nxt;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they
  // change on the same edge as the state itself
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    retries_nxt = retries_q;
`ifdef LOCK_LOSS_CNT_EN
    loss_c      = 1'b0;
`endif
    unique case (state)
      S_RESET_DCM: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_nxt = '0;
          if (retries_q == RETRY_MAX) begin
            state_nxt = S_FAIL;
          end else begin
            state_nxt   = S_RESET_DCM;
            retries_nxt = retries_q + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (!lk) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt   = S_RUN;
          cnt_nxt     = '0;
          retries_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!lk) begin
          state_nxt = S_RESET_DCM;
          cnt_nxt   = '0;
`ifdef LOCK_LOSS_CNT_EN
          loss_c    = 1'b1;
`endif
        end
      end
      S_FAIL: begin
        state_nxt = S_FAIL;
      end
      default: begin
        state_nxt = S_RESET_DCM;
        cnt_nxt   = '0;
      end
    endcase

    // Forced restart wins over everything except the sticky failure
    if (bus.relock && (state != S_FAIL)) begin
      state_nxt   = S_RESET_DCM;
      cnt_nxt     = '0;
      retries_nxt = '0;
`ifdef LOCK_LOSS_CNT_EN
      loss_c      = 1'b0;
`endif
    end

    dcm_rst_nxt = (state_nxt == S_RESET_DCM);
    sys_rst_nxt = (state_nxt != S_RUN);
    ready_nxt   = (state_nxt == S_RUN);
    fail_nxt    = (state_nxt == S_FAIL);
  end

`ifdef LOCK_LOSS_CNT_EN
  // Saturating count of lock losses seen while running
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lost_q <= '0;
    end else if (loss_c && (lost_q != 8'hFF)) begin
      lost_q <= lost_q + 1'b1;
    end
  end

  assign bus.lost_count = lost_q;
`endif

  assign bus.dcm_rst = dcm_rst_q;
  assign bus.sys_rst = sys_rst_q;
  assign bus.ready   = ready_q;
  assign bus.fail    = fail_q;
  assign bus.retries = retries_q;

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// Self-checking bench for dcm_lock_ctrl: per-cycle comparison against a
// phase/elapsed-time model plus literal timing checks for the key scenarios.
module tb_dcm_lock_ctrl;

  localparam int RST_CYCLES    = 8;
  localparam int LOCK_TIMEOUT  = 4096;
  localparam int SETTLE_CYCLES = 64;
  localparam int MAX_RETRY     = 3;

  localparam int PH_RST    = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAIL   = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  dcm_lock_ctrl_if bus ();

  dcm_lock_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (16)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int m_phase   = PH_RST;
  int m_elapsed = 0;
  int m_ret     = 0;
  int m_lost    = 0;
  bit m_hist[$];

  // cycle bookkeeping and last sampled outputs
  int   cyc = 0;
  int   c0  = 0;
  int   s_rel = 0;
  logic s_dr = 1'b0, s_sr = 1'b0, s_rdy = 1'b0, s_fl = 1'b0;
  logic [1:0] s_ret = 2'd0;
  logic prev_dr = 1'b0;
  int   cur_len = 0, last_len = 0, pulses = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at rel cycle %0d",
               name, act, act, exp, exp, s_rel);
    end
  endtask

  task automatic model_reset();
    m_phase   = PH_RST;
    m_elapsed = 0;
    m_ret     = 0;
    m_lost    = 0;
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
  endtask

  // Advance the model by one clock: lock is seen two clocks after the pin
  task automatic model_step();
    bit lk;
    lk = m_hist.pop_front();
    m_hist.push_back(bus.dcm_locked);
    if (bus.relock && m_phase != PH_FAIL) begin
      m_phase = PH_RST; m_elapsed = 0; m_ret = 0;
    end else begin
      case (m_phase)
        PH_RST: begin
          m_elapsed++;
          if (m_elapsed == RST_CYCLES) begin m_phase = PH_WAIT; m_elapsed = 0; end
        end
        PH_WAIT: begin
          m_elapsed++;
          if (lk) begin
            m_phase = PH_SETTLE; m_elapsed = 0;
          end else if (m_elapsed == LOCK_TIMEOUT) begin
            m_elapsed = 0;
            if (m_ret == MAX_RETRY) m_phase = PH_FAIL;
            else begin m_ret++; m_phase = PH_RST; end
          end
        end
        PH_SETTLE: begin
          m_elapsed++;
          if (!lk) begin
            m_phase = PH_WAIT; m_elapsed = 0;
          end else if (m_elapsed == SETTLE_CYCLES) begin
            m_phase = PH_RUN; m_elapsed = 0; m_ret = 0;
          end
        end
        PH_RUN: begin
          if (!lk) begin
            m_phase = PH_RST; m_elapsed = 0;
            if (m_lost < 255) m_lost++;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: compare on the falling edge, step the model on the rising edge
  task automatic tick();
    logic [5:0] act, exp;
    @(negedge clock);
    if (!reset_n) model_reset();
    s_dr  = bus.dcm_rst;
    s_sr  = bus.sys_rst;
    s_rdy = bus.ready;
    s_fl  = bus.fail;
    s_ret = bus.retries;
    s_rel = cyc - c0;
    act = {s_dr, s_sr, s_rdy, s_fl, s_ret};
    exp = {m_phase == PH_RST, m_phase != PH_RUN, m_phase == PH_RUN,
           m_phase == PH_FAIL, 2'(m_ret)};
    check("outputs{dcm_rst,sys_rst,ready,fail,retries}", int'(act), int'(exp));
`ifdef LOCK_LOSS_CNT_EN
    check("lost_count", int'(bus.lost_count), m_lost);
`endif
    if (s_dr) cur_len++;
    else if (prev_dr) begin last_len = cur_len; cur_len = 0; pulses++; end
    prev_dr = s_dr;
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_step();
    cyc++;
    #2;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    bus.dcm_locked = 1'b0;
    bus.relock     = 1'b0;
    repeat (3) tick();
    reset_n  = 1'b1;
    c0       = cyc;
    cur_len  = 0;
    pulses   = 0;
    prev_dr  = 1'b1;
  endtask

  task automatic run_to(input int rel);
    while ((cyc - c0) < rel) tick();
  endtask

  // which: 0 sys_rst, 1 ready, 2 fail; at = -1 if the budget expires
  task automatic wait_for(input int which, input logic val, input int budget, output int at);
    logic v;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      v = (which == 0) ? s_sr : (which == 1) ? s_rdy : s_fl;
      if (v == val) begin at = s_rel; break; end
    end
  endtask

  initial begin
    int at, lc, pb;
    bus.dcm_locked = 1'b0;
    bus.relock     = 1'b0;

    // reset values and normal lock, pin rises 200 cycles into the lock wait
    do_reset();
    tick();
    check("reset dcm_rst", int'(s_dr), 1);
    check("reset sys_rst", int'(s_sr), 1);
    check("reset ready", int'(s_rdy), 0);
    check("reset fail", int'(s_fl), 0);
    check("reset retries", int'(s_ret), 0);
    run_to(208);
    bus.dcm_locked = 1'b1;
    wait_for(0, 1'b0, 300, at);
    check("normal sys_rst release cycle", at, 275);
    check("normal dcm_rst pulse length", last_len, 8);
    check("normal pulse count", pulses, 1);
    check("normal ready", int'(s_rdy), 1);
    check("normal retries", int'(s_ret), 0);

    // lock loss while running
    repeat (10) tick();
    lc = cyc - c0;
    pb = pulses;
    bus.dcm_locked = 1'b0;
    wait_for(0, 1'b1, 20, at);
    check("loss sys_rst rise cycle", at, lc + 3);
    repeat (15) tick();
    bus.dcm_locked = 1'b1;
    wait_for(1, 1'b1, 300, at);
    check("loss relock reached", int'(at >= 0), 1);
    check("loss dcm_rst pulse length", last_len, 8);
    check("loss pulse count", pulses, pb + 1);
`ifdef LOCK_LOSS_CNT_EN
    check("loss lost_count literal", int'(bus.lost_count), 1);
`endif

    // one-cycle lock glitch at settle count 30
    do_reset();
    run_to(208);
    bus.dcm_locked = 1'b1;
    run_to(239);
    bus.dcm_locked = 1'b0;
    tick();
    bus.dcm_locked = 1'b1;
    wait_for(0, 1'b0, 300, at);
    check("glitch sys_rst release cycle", at, 307);
    check("glitch retries", int'(s_ret), 0);

    // two timeouts, then lock
    do_reset();
    run_to(8300);
    check("retry pulse count", pulses, 3);
    check("retry retries", int'(s_ret), 2);
    bus.dcm_locked = 1'b1;
    wait_for(0, 1'b0, 200, at);
    check("retry sys_rst release cycle", at, 8367);
    check("retry retries after run", int'(s_ret), 0);

    // relock with retries==2 in the lock wait
    do_reset();
    run_to(8300);
    check("relock retries before", int'(s_ret), 2);
    bus.relock = 1'b1;
    tick();
    bus.relock = 1'b0;
    tick();
    check("relock dcm_rst next cycle", int'(s_dr), 1);
    check("relock retries cleared", int'(s_ret), 0);
    repeat (10) tick();
    check("relock pulse length", last_len, 8);

    // permanent failure
    do_reset();
    wait_for(2, 1'b1, 17000, at);
    check("fail entry cycle", at, 16416);
    check("fail pulse count", pulses, 4);
    check("fail retries", int'(s_ret), 3);
    repeat (20000) tick();
    check("fail pulse count after hold", pulses, 4);
    check("fail sticky", int'(s_fl), 1);
    check("fail sys_rst", int'(s_sr), 1);
    bus.relock = 1'b1;
    tick();
    bus.relock = 1'b0;
    repeat (10) tick();
    check("fail relock ignored fail", int'(s_fl), 1);
    check("fail relock ignored dcm_rst", int'(s_dr), 0);

    // randomized lock activity with occasional relock requests
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      int len;
      bus.dcm_locked = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 400));
      for (int i = 0; i < len; i++) begin
        bus.relock = ($urandom_range(0, 49) == 0);
        tick();
      end
    end
    bus.relock = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
